// File: rtl/bellek_gc_denetleyici_pkg.sv
// Shared definitions for the memory / I/O access sequencer: state encoding,
// address decode bit, default I/O timeout and the access-type encoding.
package bellek_gc_denetleyici_pkg;

  typedef enum logic [2:0] {
    BOSTA        = 3'd0,
    BELLEK_ISTEK = 3'd1,
    BELLEK_BEKLE = 3'd2,
    GC_ISTEK     = 3'd3,
    GC_BEKLE     = 3'd4,
    TAMAM        = 3'd5
  } durum_t;

  // Address bit that selects the target: 1 = data memory, 0 = I/O.
  localparam int GC_SECIM_BITI = 30;

  localparam int VARSAYILAN_ZAMAN_ASIMI = 255;

  typedef enum logic {
    ERISIM_OKU = 1'b0,
    ERISIM_YAZ = 1'b1
  } erisim_t;

  // A store request always wins over a simultaneous load request.
  function automatic erisim_t erisim_coz(input logic yaz);
    return yaz ? ERISIM_YAZ : ERISIM_OKU;
  endfunction

endpackage

// File: rtl/bellek_gc_denetleyici_zaman_asimi_sayaci.sv
// I/O timeout counter: cleared on entry to the I/O request state, counts while
// enabled and flags the last allowed cycle (count == ZAMAN_ASIMI-1).
module zaman_asimi_sayaci #(
  parameter int ZAMAN_ASIMI = 255,
  parameter int ZA_BIT      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic temizle_i,
  input  logic etkin_i,
  output logic doldu_o
);

  localparam logic [ZA_BIT-1:0] SON_DEGER = ZA_BIT'(ZAMAN_ASIMI - 1);

  logic [ZA_BIT-1:0] r_sayac;

  always_ff @(posedge clk_i) begin
    if (rst_i || temizle_i) begin
      r_sayac <= '0;
    end else if (etkin_i) begin
      r_sayac <= r_sayac + ZA_BIT'(1);
    end
  end

  assign doldu_o = (r_sayac == SON_DEGER);

endmodule

// File: rtl/bellek_gc_denetleyici.sv
// Sequences one load/store at a time from the memory stage to the data-memory
// or I/O port, stalling the pipeline until the target handshake completes.
module bellek_gc_denetleyici
  import bellek_gc_denetleyici_pkg::*;
#(
  parameter int ADRES_BIT   = 32,
  parameter int VERI_BIT    = 32,
  parameter int ZAMAN_ASIMI = VARSAYILAN_ZAMAN_ASIMI,
  parameter int ZA_BIT      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  istek_gecerli_i,
  input  logic                  bellege_yaz_i,
  input  logic                  bellekten_oku_i,
  input  logic [ADRES_BIT-1:0]  adres_i,
  input  logic [VERI_BIT-1:0]   yaz_veri_i,
  input  logic [VERI_BIT/8-1:0] yaz_maske_i,
  output logic                  durdur_o,
  output logic [VERI_BIT-1:0]   oku_veri_o,
  output logic                  oku_gecerli_o,
  output logic                  hata_o,
  output logic                  bellek_istek_o,
  output logic                  bellek_yaz_o,
  output logic [ADRES_BIT-1:0]  bellek_adres_o,
  output logic [VERI_BIT-1:0]   bellek_veri_o,
  output logic [VERI_BIT/8-1:0] bellek_maske_o,
  input  logic                  bellek_hazir_i,
  input  logic                  bellek_yanit_i,
  input  logic [VERI_BIT-1:0]   bellek_veri_i,
  output logic                  gc_istek_o,
  output logic                  gc_yaz_o,
  output logic [ADRES_BIT-1:0]  gc_adres_o,
  output logic [VERI_BIT-1:0]   gc_veri_o,
  output logic [VERI_BIT/8-1:0] gc_maske_o,
  input  logic                  gc_hazir_i,
  input  logic                  gc_yanit_i,
  input  logic [VERI_BIT-1:0]   gc_veri_i
);

  // Handshake: istek_o stays high with stable fields until hazir_i is seen
  // high on a rising edge; the response is the first cycle yanit_i is high
  // from that same edge onwards.
  durum_t  r_durum;
  erisim_t r_tip;

  logic w_kabul, w_bellek_sec, w_bellek_yolu, w_gc_yolu;
  logic w_istek_durumu, w_bekle_durumu;
  logic w_hazir, w_yanit, w_tamamla, w_zaman_asimi, w_doldu;
  logic [VERI_BIT-1:0] w_gelen_veri;

  assign w_kabul        = istek_gecerli_i && (bellege_yaz_i || bellekten_oku_i);
  assign w_bellek_sec   = adres_i[GC_SECIM_BITI];
  assign w_bellek_yolu  = (r_durum == BELLEK_ISTEK) || (r_durum == BELLEK_BEKLE);
  assign w_gc_yolu      = (r_durum == GC_ISTEK) || (r_durum == GC_BEKLE);
  assign w_istek_durumu = (r_durum == BELLEK_ISTEK) || (r_durum == GC_ISTEK);
  assign w_bekle_durumu = (r_durum == BELLEK_BEKLE) || (r_durum == GC_BEKLE);

  assign w_hazir      = w_bellek_yolu ? bellek_hazir_i : gc_hazir_i;
  assign w_yanit      = w_bellek_yolu ? bellek_yanit_i : gc_yanit_i;
  assign w_gelen_veri = w_bellek_yolu ? bellek_veri_i  : gc_veri_i;

  // A response arriving in the expiry cycle takes priority over the timeout.
  assign w_tamamla     = (w_istek_durumu && w_hazir && w_yanit) ||
                         (w_bekle_durumu && w_yanit);
  assign w_zaman_asimi = w_gc_yolu && w_doldu && !w_tamamla;

  assign durdur_o = ((r_durum != BOSTA) && (r_durum != TAMAM)) ||
                    ((r_durum == BOSTA) && w_kabul);

  zaman_asimi_sayaci #(
    .ZAMAN_ASIMI (ZAMAN_ASIMI),
    .ZA_BIT      (ZA_BIT)
  ) u_zaman_asimi_sayaci (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .temizle_i ((r_durum == BOSTA) && w_kabul && !w_bellek_sec),
    .etkin_i   (w_gc_yolu),
    .doldu_o   (w_doldu)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum        <= BOSTA;
      r_tip          <= ERISIM_OKU;
      oku_veri_o     <= '0;
      oku_gecerli_o  <= 1'b0;
      hata_o         <= 1'b0;
      bellek_istek_o <= 1'b0;
      bellek_yaz_o   <= 1'b0;
      bellek_adres_o <= '0;
      bellek_veri_o  <= '0;
      bellek_maske_o <= '0;
      gc_istek_o     <= 1'b0;
      gc_yaz_o       <= 1'b0;
      gc_adres_o     <= '0;
      gc_veri_o      <= '0;
      gc_maske_o     <= '0;
    end else begin
      oku_gecerli_o <= 1'b0;
      hata_o        <= 1'b0;
      if (w_tamamla) begin
        r_durum        <= TAMAM;
        bellek_istek_o <= 1'b0;
        gc_istek_o     <= 1'b0;
        if (r_tip == ERISIM_OKU) begin
          oku_veri_o    <= w_gelen_veri;
          oku_gecerli_o <= 1'b1;
        end
      end else if (w_zaman_asimi) begin
        r_durum    <= TAMAM;
        gc_istek_o <= 1'b0;
        hata_o     <= 1'b1;
      end else begin
        case (r_durum)
          BOSTA: begin
            if (w_kabul) begin
              r_tip <= erisim_coz(bellege_yaz_i);
              if (w_bellek_sec) begin
                r_durum        <= BELLEK_ISTEK;
                bellek_istek_o <= 1'b1;
                bellek_yaz_o   <= bellege_yaz_i;
                bellek_adres_o <= adres_i;
                bellek_veri_o  <= yaz_veri_i;
                bellek_maske_o <= yaz_maske_i;
              end else begin
                r_durum    <= GC_ISTEK;
                gc_istek_o <= 1'b1;
                gc_yaz_o   <= bellege_yaz_i;
                gc_adres_o <= adres_i;
                gc_veri_o  <= yaz_veri_i;
                gc_maske_o <= yaz_maske_i;
              end
            end
          end
          BELLEK_ISTEK: begin
            if (w_hazir) begin
              r_durum        <= BELLEK_BEKLE;
              bellek_istek_o <= 1'b0;
            end
          end
          GC_ISTEK: begin
            if (w_hazir) begin
              r_durum    <= GC_BEKLE;
              gc_istek_o <= 1'b0;
            end
          end
          BELLEK_BEKLE, GC_BEKLE: r_durum <= r_durum;
          TAMAM:   r_durum <= BOSTA;
          default: r_durum <= BOSTA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bellek_gc_denetleyici.sv
// Directed bench for bellek_gc_denetleyici: a transaction-level timing model
// fills per-cycle expectations that one compare process checks every cycle.
module tb_bellek_gc_denetleyici;

  localparam int AB = 32;
  localparam int VB = 32;
  localparam int Z  = 8;
  localparam int N  = 1024;
  localparam int SONSUZ = 1000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          istek_gecerli = 1'b0, bellege_yaz = 1'b0, bellekten_oku = 1'b0;
  logic [AB-1:0] adres = '0;
  logic [VB-1:0] yaz_veri = '0;
  logic [3:0]    yaz_maske = '0;
  logic          durdur, oku_gecerli, hata;
  logic [VB-1:0] oku_veri;
  logic          bellek_istek, bellek_yaz, gc_istek, gc_yaz;
  logic [AB-1:0] bellek_adres, gc_adres;
  logic [VB-1:0] bellek_veri_o, gc_veri_o;
  logic [3:0]    bellek_maske, gc_maske;
  logic          bellek_hazir = 1'b0, bellek_yanit = 1'b0;
  logic          gc_hazir = 1'b0, gc_yanit = 1'b0;
  logic [VB-1:0] bellek_veri_i = '0, gc_veri_i = '0;

  bellek_gc_denetleyici #(
    .ADRES_BIT (AB), .VERI_BIT (VB), .ZAMAN_ASIMI (Z), .ZA_BIT (8)
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .istek_gecerli_i (istek_gecerli), .bellege_yaz_i (bellege_yaz),
    .bellekten_oku_i (bellekten_oku), .adres_i (adres),
    .yaz_veri_i (yaz_veri), .yaz_maske_i (yaz_maske),
    .durdur_o (durdur), .oku_veri_o (oku_veri),
    .oku_gecerli_o (oku_gecerli), .hata_o (hata),
    .bellek_istek_o (bellek_istek), .bellek_yaz_o (bellek_yaz),
    .bellek_adres_o (bellek_adres), .bellek_veri_o (bellek_veri_o),
    .bellek_maske_o (bellek_maske), .bellek_hazir_i (bellek_hazir),
    .bellek_yanit_i (bellek_yanit), .bellek_veri_i (bellek_veri_i),
    .gc_istek_o (gc_istek), .gc_yaz_o (gc_yaz), .gc_adres_o (gc_adres),
    .gc_veri_o (gc_veri_o), .gc_maske_o (gc_maske),
    .gc_hazir_i (gc_hazir), .gc_yanit_i (gc_yanit), .gc_veri_i (gc_veri_i)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int kontrol_say = 0;
  int hata_say    = 0;

  // Per-cycle expectations produced by the transaction model.
  bit exp_durdur[N], exp_gecerli[N], exp_hata[N], exp_bistek[N], exp_gistek[N];
  bit guncelle[N];
  logic [VB-1:0] yeni[N];
  logic [VB-1:0] exp_q[$];
  logic [AB-1:0] m_adres;
  logic [VB-1:0] m_veri, m_oku_veri;
  logic [3:0]    m_maske;
  logic          m_yaz;

  bit kontrol_acik = 0;
  int say_durdur, say_bistek, say_gistek;
  int gecerli_cyc_q[$], hata_cyc_q[$];
  logic son_bellek_yaz = 1'b0;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    kontrol_say++;
    if (gercek !== beklenen) begin
      hata_say++;
      $display("FAIL %s: gercek=%h beklenen=%h (cyc %0d)", ad, gercek, beklenen, cyc);
    end
  endtask

  // Compare process: every non-reset cycle, half a period after the edge.
  initial begin
    m_oku_veri = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_oku_veri = '0;
      end else if (kontrol_acik && cyc < N) begin
        if (guncelle[cyc]) m_oku_veri = yeni[cyc];
        kontrol("durdur", durdur, exp_durdur[cyc]);
        kontrol("oku_gecerli", oku_gecerli, exp_gecerli[cyc]);
        kontrol("hata", hata, exp_hata[cyc]);
        kontrol("bellek_istek", bellek_istek, exp_bistek[cyc]);
        kontrol("gc_istek", gc_istek, exp_gistek[cyc]);
        kontrol("oku_veri", oku_veri, m_oku_veri);
        if (exp_bistek[cyc]) begin
          kontrol("bellek_adres", bellek_adres, m_adres);
          kontrol("bellek_veri", bellek_veri_o, m_veri);
          kontrol("bellek_maske", bellek_maske, m_maske);
          kontrol("bellek_yaz", bellek_yaz, m_yaz);
        end
        if (exp_gistek[cyc]) begin
          kontrol("gc_adres", gc_adres, m_adres);
          kontrol("gc_veri", gc_veri_o, m_veri);
          kontrol("gc_maske", gc_maske, m_maske);
          kontrol("gc_yaz", gc_yaz, m_yaz);
        end
        if (oku_gecerli) begin
          gecerli_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) kontrol("beklenmeyen_okuma", 1, 0);
          else kontrol("okuma_verisi", oku_veri, exp_q.pop_front());
        end
        if (hata) hata_cyc_q.push_back(cyc);
        if (bellek_istek) son_bellek_yaz = bellek_yaz;
        say_durdur += int'(durdur);
        say_bistek += int'(bellek_istek);
        say_gistek += int'(gc_istek);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic sayaclari_sifirla();
    say_durdur = 0;
    say_bistek = 0;
    say_gistek = 0;
  endtask

  // One access. The target raises hazir hz cycles after the first request
  // cycle and yanit yn cycles after hazir (yn < 0: never); both stay high
  // until the access ends. Called at the start of an idle cycle.
  task automatic erisim(input logic yaz, input logic oku, input logic [AB-1:0] adr,
                        input logic [VB-1:0] veri, input logic [3:0] maske,
                        input int hz, input int yn, input logic [VB-1:0] cevap,
                        output int a_o, output int t_o);
    int a, e, h, y, t, istek_son;
    bit bellek, zaman_asti, yukle;
    a = cyc;
    e = a + 1;
    h = e + hz;
    y = (yn < 0) ? SONSUZ : h + yn;
    bellek = adr[30];
    zaman_asti = 0;
    if (bellek || y <= e + Z - 1) t = y + 1;
    else begin
      t = e + Z;
      zaman_asti = 1;
    end
    yukle = !yaz && oku;
    istek_son = (h < t - 1) ? h : t - 1;
    for (int c = a; c < t; c++) exp_durdur[c] = 1;
    for (int c = e; c <= istek_son; c++) begin
      if (bellek) exp_bistek[c] = 1;
      else exp_gistek[c] = 1;
    end
    exp_hata[t] = zaman_asti;
    exp_gecerli[t] = yukle && !zaman_asti;
    if (yukle && !zaman_asti) begin
      guncelle[t] = 1;
      yeni[t] = cevap;
      exp_q.push_back(cevap);
    end
    m_adres = adr; m_veri = veri; m_maske = maske; m_yaz = yaz;

    istek_gecerli = 1'b1; bellege_yaz = yaz; bellekten_oku = oku;
    adres = adr; yaz_veri = veri; yaz_maske = maske;
    for (int c = e; c <= t; c++) begin
      @(posedge clk); #1;
      istek_gecerli = 1'b0; bellege_yaz = 1'b0; bellekten_oku = 1'b0;
      if (bellek) begin
        bellek_hazir = (cyc >= h); bellek_yanit = (cyc >= y); bellek_veri_i = cevap;
      end else begin
        gc_hazir = (cyc >= h); gc_yanit = (cyc >= y); gc_veri_i = cevap;
      end
    end
    @(posedge clk); #1;
    bellek_hazir = 1'b0; bellek_yanit = 1'b0; gc_hazir = 1'b0; gc_yanit = 1'b0;
    a_o = a;
    t_o = t;
  endtask

  initial begin
    int a, t, a2, t2, ng, nh;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    kontrol_acik = 1;

    // Reset values.
    kontrol("rst_durdur", durdur, 0);
    kontrol("rst_oku_veri", oku_veri, 0);
    kontrol("rst_oku_gecerli", oku_gecerli, 0);
    kontrol("rst_hata", hata, 0);
    kontrol("rst_bellek_istek", bellek_istek, 0);
    kontrol("rst_bellek_yaz", bellek_yaz, 0);
    kontrol("rst_bellek_adres", bellek_adres, 0);
    kontrol("rst_bellek_veri", bellek_veri_o, 0);
    kontrol("rst_bellek_maske", bellek_maske, 0);
    kontrol("rst_gc_istek", gc_istek, 0);
    kontrol("rst_gc_yaz", gc_yaz, 0);
    kontrol("rst_gc_adres", gc_adres, 0);
    kontrol("rst_gc_veri", gc_veri_o, 0);
    kontrol("rst_gc_maske", gc_maske, 0);

    // Zero-wait memory load.
    sayaclari_sifirla();
    erisim(1'b0, 1'b1, 32'h4000_0010, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, a, t);
    kontrol("t1_durdur_say", say_durdur, 2);
    kontrol("t1_bistek_say", say_bistek, 1);
    kontrol("t1_gistek_say", say_gistek, 0);
    kontrol("t1_gecerli_gecikme", gecerli_cyc_q[gecerli_cyc_q.size()-1] - a, 2);
    kontrol("t1_oku_veri", oku_veri, 32'hDEAD_BEEF);

    // I/O store with a slow target.
    sayaclari_sifirla();
    ng = gecerli_cyc_q.size(); nh = hata_cyc_q.size();
    erisim(1'b1, 1'b0, 32'h0000_0004, 32'h55, 4'h1, 3, 2, 32'h0, a, t);
    kontrol("t2_durdur_say", say_durdur, 7);
    kontrol("t2_gecerli_yok", gecerli_cyc_q.size(), ng);
    kontrol("t2_hata_yok", hata_cyc_q.size(), nh);

    // I/O load that never gets a response: timeout.
    sayaclari_sifirla();
    erisim(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 0, -1, 32'h0, a, t);
    kontrol("t3_hata_gecikme", hata_cyc_q[hata_cyc_q.size()-1] - (a + 1), 8);
    kontrol("t3_oku_veri_sabit", oku_veri, 32'hDEAD_BEEF);
    kontrol("t3_durdur_say", say_durdur, 9);

    // Response in the expiry cycle wins.
    nh = hata_cyc_q.size();
    erisim(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'h0, 0, 7, 32'h1234_5678, a, t);
    kontrol("t3b_hata_yok", hata_cyc_q.size(), nh);
    kontrol("t3b_oku_veri", oku_veri, 32'h1234_5678);

    // Target never ready: request held for the whole timeout window.
    sayaclari_sifirla();
    erisim(1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'h0, 20, 0, 32'h0, a, t);
    kontrol("t3c_gistek_say", say_gistek, 8);
    kontrol("t3c_oku_veri_sabit", oku_veri, 32'h1234_5678);

    // Store and load both set: store wins.
    ng = gecerli_cyc_q.size();
    erisim(1'b1, 1'b1, 32'h4000_0000, 32'hA5A5_0F0F, 4'hC, 1, 1, 32'hFFFF_FFFF, a, t);
    kontrol("t4_bellek_yaz", son_bellek_yaz, 1);
    kontrol("t4_gecerli_yok", gecerli_cyc_q.size(), ng);

    // Valid request with neither load nor store is not accepted.
    sayaclari_sifirla();
    istek_gecerli = 1'b1; adres = 32'h4000_0000;
    @(posedge clk); #1;
    istek_gecerli = 1'b0;
    @(posedge clk); #1;
    kontrol("t5_durdur_say", say_durdur, 0);
    kontrol("t5_bistek_say", say_bistek, 0);

    // Reset while waiting for the memory response; late response ignored.
    a = cyc;
    exp_durdur[a] = 1; exp_durdur[a+1] = 1; exp_durdur[a+2] = 1; exp_bistek[a+1] = 1;
    m_adres = 32'h4000_0020; m_veri = 32'h0; m_maske = 4'h0; m_yaz = 1'b0;
    ng = gecerli_cyc_q.size();
    istek_gecerli = 1'b1; bellekten_oku = 1'b1; adres = 32'h4000_0020;
    yaz_veri = 32'h0; yaz_maske = 4'h0;
    @(posedge clk); #1;
    istek_gecerli = 1'b0; bellekten_oku = 1'b0; bellek_hazir = 1'b1;
    @(posedge clk); #1;
    bellek_hazir = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bellek_yanit = 1'b1; bellek_veri_i = 32'hBAD0_BAD0;
    kontrol("t6_bellek_istek", bellek_istek, 0);
    kontrol("t6_oku_veri", oku_veri, 0);
    kontrol("t6_bellek_adres", bellek_adres, 0);
    kontrol("t6_durdur", durdur, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bellek_yanit = 1'b0;
    kontrol("t6_gecerli_yok", gecerli_cyc_q.size(), ng);

    // Back-to-back zero-wait loads: memory then I/O.
    erisim(1'b0, 1'b1, 32'h4000_0040, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D, a, t);
    erisim(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'hCAFE_0001, a2, t2);
    kontrol("t7_arka_arkaya_kabul", a2 - a, 3);
    kontrol("t7_darbe_araligi",
            gecerli_cyc_q[gecerli_cyc_q.size()-1] - gecerli_cyc_q[gecerli_cyc_q.size()-2], 3);
    kontrol("t7_oku_veri", oku_veri, 32'hCAFE_0001);

    repeat (2) @(posedge clk);
    #1;
    kontrol("exp_q_bos", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", kontrol_say, hata_say);
    $finish;
  end

endmodule

// File: doc/bellek_gc_denetleyici.md
Name: bellek_gc_denetleyici

Overview:
- Sequences one load/store from the memory stage to either the data-memory port or the peripheral (I/O) port; one access in flight at a time.
- Decodes address bit 30: 1 = memory, 0 = I/O.
- Holds the pipeline with durdur_o until the selected target completes the valid/ready request and response handshake.
- Bounds I/O accesses with a timeout and reports an error pulse on expiry.

Parameters:
- ADRES_BIT, 32, address width
- VERI_BIT, 32, data width
- ZAMAN_ASIMI, 255, I/O timeout in cycles counted from entry to GC_ISTEK (must be >= 1)
- ZA_BIT, 8, timeout counter width (2^ZA_BIT > ZAMAN_ASIMI)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset
- istek_gecerli_i  in  1  memory stage presents an access
- bellege_yaz_i  in  1  store
- bellekten_oku_i  in  1  load
- adres_i  in  ADRES_BIT  access address
- yaz_veri_i  in  VERI_BIT  store data
- yaz_maske_i  in  VERI_BIT/8  byte enables
- durdur_o  out  1  stall pipeline
- oku_veri_o  out  VERI_BIT  load result, held until next completion
- oku_gecerli_o  out  1  one-cycle pulse, load result valid
- hata_o  out  1  one-cycle pulse, I/O timeout
- bellek_istek_o, bellek_yaz_o  out  1  memory request, write flag
- bellek_adres_o, bellek_veri_o, bellek_maske_o  out  ADRES_BIT/VERI_BIT/VERI_BIT/8  latched fields
- bellek_hazir_i  in  1  memory accepts request
- bellek_yanit_i  in  1  memory response
- bellek_veri_i  in  VERI_BIT  memory read data
- gc_istek_o, gc_yaz_o, gc_adres_o, gc_veri_o, gc_maske_o  out  same as bellek_* for I/O
- gc_hazir_i, gc_yanit_i, gc_veri_i  in  same as bellek_* for I/O

Interface decision (fixed): single clock clk_i; rst_i is synchronous and active-high.

Behaviour:
- States: BOSTA, BELLEK_ISTEK, BELLEK_BEKLE, GC_ISTEK, GC_BEKLE, TAMAM.
- Reset:
  - State BOSTA, counter 0.
  - All outputs 0, including oku_veri_o and every latched field.
  - Reset mid-access aborts the access; istek outputs are low in the first cycle after reset.
  - A late hazir/yanit arriving in BOSTA is ignored.
- BOSTA:
  - An access is accepted when istek_gecerli_i and (yaz or oku). Latch adres, veri, maske, and type.
  - Write wins if both yaz and oku are set; the read is dropped.
  - adres_i[30]=1 -> BELLEK_ISTEK; adres_i[30]=0 -> GC_ISTEK.
  - durdur_o is combinationally high in the accept cycle.
- *_ISTEK:
  - istek_o=1 with latched fields held stable; *_yaz_o = latched type.
  - The non-selected port's istek_o stays 0.
  - hazir_i=1 -> *_BEKLE. If yanit_i is also 1 in the same cycle, go directly to TAMAM and capture data.
- *_BEKLE: istek_o=0; on yanit_i=1 capture *_veri_i (loads only) -> TAMAM.
- TAMAM:
  - durdur_o=0; the pipeline advances this cycle.
  - Loads: oku_gecerli_o=1 and oku_veri_o updated (registered; visible in this cycle).
  - Stores: no oku_gecerli_o.
  - Inputs are ignored in this cycle -> BOSTA.
- durdur_o = (state ∉ {BOSTA, TAMAM}) or (BOSTA and accept).
- Timeout:
  - The counter clears on entry to GC_ISTEK and increments every cycle in GC_ISTEK and GC_BEKLE.
  - When count == ZAMAN_ASIMI-1 and no yanit_i -> TAMAM with hata_o=1, oku_gecerli_o=0, oku_veri_o unchanged.
  - yanit_i in the same cycle as expiry: the response wins and there is no error.
  - The memory path has no timeout.
- Latency: zero-wait target (hazir and yanit in the first ISTEK cycle) gives accept cycle N, ISTEK N+1, TAMAM N+2. durdur_o is high for 2 cycles.
- Back-to-back: a new access can be accepted in the BOSTA cycle immediately after TAMAM.

Decomposition:
- Shared package/include:
  - State encoding (3-bit localparams).
  - GC_SECIM_BITI = 30.
  - Default ZAMAN_ASIMI.
  - The access-type encoding, shared with the existing memory/I/O decode logic.
- One sub-module: zaman_asimi_sayaci (clear, enable, expiry flag; parameterised by ZAMAN_ASIMI/ZA_BIT).

Test Plan:
- Memory load, adres 0x4000_0010, bellek_hazir and bellek_yanit tied 1, bellek_veri 0xDEAD_BEEF -> bellek_istek_o high 1 cycle; durdur_o high 2 cycles; cycle 3 oku_gecerli_o=1, oku_veri_o=0xDEAD_BEEF; gc_istek_o never high.
- I/O store, adres 0x0000_0004, veri 0x55, maske 0x1; gc_hazir delayed 3 cycles, gc_yanit 2 cycles later -> gc_* fields stable throughout; durdur_o high 7 cycles; no oku_gecerli_o, no hata_o.
- I/O load with gc_hazir=1 and gc_yanit never, ZAMAN_ASIMI=8 -> hata_o pulses exactly 8 cycles after GC_ISTEK entry; oku_veri_o keeps its previous value; durdur_o drops that cycle.
- Both bellege_yaz_i and bellekten_oku_i set, adres 0x4000_0000 -> bellek_yaz_o=1; no oku_gecerli_o.
- rst_i asserted while in BELLEK_BEKLE, bellek_yanit_i raised the cycle after -> all outputs 0; yanit ignored; the next access starts from BOSTA normally.
- Back-to-back load memory then load I/O, zero-wait -> second accepted in the cycle after TAMAM; two oku_gecerli_o pulses 3 cycles apart.
